mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares one single-port synchronous main memory (SPRAM, 1-cycle read latency) between the CPU pipeline (port 0) and a secondary master such as a UART loader or DMA (port 1).
- Port 0 has fixed priority; a starvation counter forces a grant to port 1 after a bounded wait.
- Sits between the masters and the memory macro, in the memory address decode for the main region.

Parameters:
- ADDR_WIDTH, 14: word-address width driven to memory.
- STARVE_LIMIT, 8: consecutive cycles port 1 may be denied before it is forced; range 1..255.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- p0_req  input  1  port 0 access request, held until granted
- p0_write  input  1  port 0 write (1) / read (0)
- p0_wmask  input  4  port 0 byte enables
- p0_wdata  input  32  port 0 write data
- p0_addr  input  ADDR_WIDTH  port 0 word address
- p0_gnt  output  1  port 0 request accepted this cycle
- p0_rvalid  output  1  port 0 read data valid
- p0_rdata  output  32  port 0 read data
- p1_req, p1_write, p1_wmask, p1_wdata, p1_addr  inputs  (same widths)  port 1 request
- p1_gnt, p1_rvalid, p1_rdata  outputs  (same widths)  port 1 response
- mem_write  output  1  memory write strobe
- mem_wmask  output  4  memory byte enables
- mem_wdata  output  32  memory write data
- mem_addr  output  ADDR_WIDTH  memory word address
- mem_rdata  input  32  memory read data, valid the cycle after the address

Behaviour:
- Reset values (rstn low, asynchronous): p0_rvalid=0, p1_rvalid=0, starvation counter=0, force flag=0. Gnt outputs are combinational, so they are 0 whenever req=0.
- Grant is combinational in the request cycle:
  - force=0: p0_gnt=p0_req; p1_gnt=p1_req & ~p0_req.
  - force=1: p1_gnt=p1_req; p0_gnt=p0_req & ~p1_req.
- Exactly one gnt is high at a time, or none.
- Memory mux: the granted port drives addr/wdata/wmask/write. With no grant: mem_write=0, mem_wmask=0, mem_addr=p0_addr, mem_wdata=p0_wdata.
- mem_write = gnt & write of the winner. Wmask passes through only on writes and is 0 on reads.
- Read latency:
  - A granted read asserts pN_rvalid for exactly 1 cycle, in the cycle after the grant.
  - pN_rdata = mem_rdata, routed to both ports; it is only meaningful with rvalid.
  - Writes produce no rvalid.
- Back-to-back:
  - A port may be granted every cycle.
  - rvalid from the grant in cycle N coincides with the grant in cycle N+1.
  - Port switching costs no bubble.
- Starvation counter (8-bit):
  - Increments when p1_req=1 and p1_gnt=0.
  - Clears to 0 whenever p1_gnt=1 or p1_req=0.
  - Saturates at STARVE_LIMIT.
  - force is registered: it is set when the counter reaches STARVE_LIMIT, so it is active in the cycle after the counter hits the limit.
  - force clears in the cycle following a p1 grant. It holds for exactly one p1 grant, then priority returns to port 0.
- p1_req dropped while force=1: force clears and the counter clears. Port 0 is granted normally in that cycle, because force only blocks port 0 when p1_req=1.
- Requests are not registered. A master that drops req before gnt simply loses the slot, with no side effects.
- Reset mid-read: a pending rvalid is discarded (rvalid=0 after reset), and the counter and force clear.
- Address width: no truncation or decode inside the block. Upper address bits are the caller's concern.

Test Plan:
- Reset: hold rstn=0 while both req=1 -> rvalid=0 on both ports, counter=0. Release; the first cycle grants port 0 only.
- Solo read: p1 reads addr 0x0010 with memory word 0xDEADBEEF, p0 idle -> p1_gnt same cycle, mem_addr=0x0010, p1_rvalid next cycle with p1_rdata=0xDEADBEEF; p0_rvalid stays 0.
- Byte write: p0 write wmask=4'b0100, wdata=0x00AB0000, addr 0x0003 -> mem_write=1, mem_wmask=0100 for one cycle; a later read of 0x0003 shows only byte 2 changed to 0xAB.
- Conflict with default priority: both req continuously, STARVE_LIMIT=8 -> p0 granted for 8 cycles, p1 granted in cycle 9 (force set), p0 granted again in cycle 10; the pattern repeats.
- Back-to-back alternation: p0 read at cycle N and p1 read at N+1 -> p0_rvalid at N+1 and p1_rvalid at N+2, no bubble, correct data on each.
- Mid-op reset: assert rstn low asynchronously between a read grant and its rvalid -> rvalid never asserts; force/counter read 0 after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two master ports and the memory macro port for mem_arbiter.
// The slave modport is the arbiter's view of the bundle; master is the opposite side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  p0_req;
  logic                  p0_write;
  logic [3:0]            p0_wmask;
  logic [31:0]           p0_wdata;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [31:0]           p0_rdata;

  logic                  p1_req;
  logic                  p1_write;
  logic [3:0]            p1_wmask;
  logic [31:0]           p1_wdata;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [31:0]           p1_rdata;

  logic                  mem_write;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport slave (
    input  p0_req, p0_write, p0_wmask, p0_wdata, p0_addr,
    input  p1_req, p1_write, p1_wmask, p1_wdata, p1_addr,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_write, mem_wmask, mem_wdata, mem_addr
  );

  modport master (
    output p0_req, p0_write, p0_wmask, p0_wdata, p0_addr,
    output p1_req, p1_write, p1_wmask, p1_wdata, p1_addr,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_write, mem_wmask, mem_wdata, mem_addr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port fixed-priority arbiter in front of a single-port SRAM (1-cycle read latency).
// Port 0 wins by default; port 1 is forced through after STARVE_LIMIT consecutive denials.
//
// state     | meaning
// ST_NORMAL | port 0 has priority
// ST_FORCE  | port 1 has starved; it wins its next request
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          rstn,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            starve_q, starve_d;
  logic                  p0_rvalid_q, p1_rvalid_q;
  logic                  gnt0, gnt1;
  logic                  write_sel;
  logic [3:0]            wmask_sel;
  logic [31:0]           wdata_sel;
  logic [ADDR_WIDTH-1:0] addr_sel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_NORMAL;
      starve_q    <= 8'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      p0_rvalid_q <= gnt0 & ~bus.p0_write;
      p1_rvalid_q <= gnt1 & ~bus.p1_write;
    end
  end

  // Force is taken from the next counter value so it applies the cycle after the limit is hit
  always_comb begin
    starve_d = starve_q;
    state_d  = ST_NORMAL;
    if (!bus.p1_req || gnt1) begin
      starve_d = 8'd0;
    end else if (starve_q < LIMIT) begin
      starve_d = 8'(starve_q + 8'd1);
    end
    if (bus.p1_req && !gnt1 && (state_q == ST_FORCE || starve_d == LIMIT)) begin
      state_d = ST_FORCE;
    end
  end

  always_comb begin
    gnt1      = bus.p1_req & ((state_q == ST_FORCE) | ~bus.p0_req);
    gnt0      = bus.p0_req & ~gnt1;
    write_sel = gnt0 & bus.p0_write;
    wmask_sel = (gnt0 & bus.p0_write) ? bus.p0_wmask : 4'd0;
    wdata_sel = bus.p0_wdata;
    addr_sel  = bus.p0_addr;
    if (gnt1) begin
      write_sel = bus.p1_write;
      wmask_sel = bus.p1_write ? bus.p1_wmask : 4'd0;
      wdata_sel = bus.p1_wdata;
      addr_sel  = bus.p1_addr;
    end
  end

  assign bus.p0_gnt    = gnt0;
  assign bus.p1_gnt    = gnt1;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;
  assign bus.mem_write = write_sel;
  assign bus.mem_wmask = wmask_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_addr  = addr_sel;

endmodule
